// File: rtl/taxi_axis_gmii_rx_if.sv
// AXI-Stream style interface used for the receive frame output.
//   tdata  : DATA_W-bit payload byte
//   tvalid : beat qualifier
//   tready : sink ready (not honoured by the GMII receiver, which cannot stall)
//   tlast  : final beat of a frame
//   tuser  : sideband; bit 0 flags a bad frame
interface taxi_axis_if #(
    parameter int DATA_W = 8,
    parameter int USER_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [USER_W-1:0] tuser;

    modport src (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport snk (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/taxi_axis_gmii_rx.sv
// GMII/MII receive framer: strips preamble/SFD, delays payload by the 4-byte
// FCS so it can be dropped, checks CRC-32 and flags bad frames on tuser[0].
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   gmii_rxd/_rx_dv/_rx_er receive data, data valid, error
//   m_axis_rx             frame output (tready ignored, no backpressure)
//   clk_enable            cycle qualifier; disabled cycles hold all state
//   mii_select            1 = 4-bit MII nibble mode (low nibble first)
//   cfg_rx_enable         accept new frames (sampled only between frames)
//   start_packet          pulse when an SFD is accepted
//   error_bad_frame       pulse on runt / rx_er / truncated FCS / odd nibbles
//   error_bad_fcs         pulse on CRC mismatch
module taxi_axis_gmii_rx #(
    parameter int DATA_W = 8,
    parameter int USER_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] gmii_rxd,
    input  logic              gmii_rx_dv,
    input  logic              gmii_rx_er,
    taxi_axis_if.src          m_axis_rx,
    input  logic              clk_enable,
    input  logic              mii_select,
    input  logic              cfg_rx_enable,
    output logic              start_packet,
    output logic              error_bad_frame,
    output logic              error_bad_fcs
);
    localparam int          LINE_LEN    = 5;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_PAYLOAD, ST_DROP} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        count_reg, count_next;
    logic [31:0]       crc_reg, crc_next;
    logic              er_seen_reg, er_seen_next;
    logic              phase_reg, phase_next;        // MII: 1 = low nibble held
    logic [3:0]        lo_nib_reg, lo_nib_next;
    logic [3:0]        prev_nib_reg, prev_nib_next;  // MII preamble sliding window
    logic [DATA_W-1:0] line_reg [LINE_LEN];
    logic [DATA_W-1:0] tdata_reg, tdata_next;
    logic              tvalid_reg, tvalid_next;
    logic              tlast_reg, tlast_next;
    logic              tuser_reg, tuser_next;
    logic              start_reg, start_next;
    logic              bad_frame_reg, bad_frame_next;
    logic              bad_fcs_reg, bad_fcs_next;

    logic              shift_en;
    logic              byte_ok;
    logic [DATA_W-1:0] cur_byte;
    logic              frame_bad;
    logic              fcs_bad;
    logic              unused_tready;

    assign unused_tready = m_axis_rx.tready;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] r;
        r = crc;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ data[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        crc_next       = crc_reg;
        er_seen_next   = er_seen_reg;
        phase_next     = phase_reg;
        lo_nib_next    = lo_nib_reg;
        prev_nib_next  = prev_nib_reg;
        tdata_next     = tdata_reg;
        tvalid_next    = tvalid_reg;
        tlast_next     = tlast_reg;
        tuser_next     = tuser_reg;
        start_next     = start_reg;
        bad_frame_next = bad_frame_reg;
        bad_fcs_next   = bad_fcs_reg;
        shift_en       = 1'b0;
        byte_ok        = 1'b0;
        cur_byte       = gmii_rxd;
        frame_bad      = 1'b0;
        fcs_bad        = 1'b0;

        if (clk_enable) begin
            // Pending output beats/pulses are consumed by this enabled cycle.
            tvalid_next    = 1'b0;
            tlast_next     = 1'b0;
            tuser_next     = 1'b0;
            start_next     = 1'b0;
            bad_frame_next = 1'b0;
            bad_fcs_next   = 1'b0;

            if (mii_select) begin
                if (state_reg == ST_PAYLOAD) begin
                    byte_ok  = gmii_rx_dv & phase_reg;
                    cur_byte = {gmii_rxd[3:0], lo_nib_reg};
                end else begin
                    // Preamble: every nibble forms a byte with the previous one.
                    byte_ok  = gmii_rx_dv;
                    cur_byte = {gmii_rxd[3:0], prev_nib_reg};
                end
            end else begin
                byte_ok = gmii_rx_dv;
            end

            if (gmii_rx_dv) begin
                prev_nib_next = gmii_rxd[3:0];
            end

            case (state_reg)
                ST_IDLE: begin
                    count_next   = '0;
                    crc_next     = '1;
                    er_seen_next = 1'b0;
                    phase_next   = 1'b0;
                    if (gmii_rx_dv) begin
                        state_next = cfg_rx_enable ? ST_PREAMBLE : ST_DROP;
                    end
                end
                ST_PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state_next = ST_IDLE;
                    end else if (gmii_rx_er) begin
                        state_next = ST_DROP;
                    end else if (cur_byte == 8'h55) begin
                        state_next = ST_PREAMBLE;
                    end else if (cur_byte == 8'hD5) begin
                        // SFD fixes the nibble phase: next nibble is a low nibble.
                        state_next = ST_PAYLOAD;
                        start_next = 1'b1;
                        phase_next = 1'b0;
                    end else begin
                        state_next = ST_DROP;
                    end
                end
                ST_PAYLOAD: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rx_er) begin
                            er_seen_next = 1'b1;
                        end
                        if (mii_select) begin
                            phase_next = ~phase_reg;
                            if (!phase_reg) begin
                                lo_nib_next = gmii_rxd[3:0];
                            end
                        end
                        if (byte_ok) begin
                            shift_en = 1'b1;
                            crc_next = crc32_byte(crc_reg, cur_byte);
                            if (count_reg == 3'(LINE_LEN)) begin
                                tdata_next  = line_reg[LINE_LEN-1];
                                tvalid_next = 1'b1;
                            end else begin
                                count_next = count_reg + 3'd1;
                            end
                        end
                    end else begin
                        state_next = ST_IDLE;
                        count_next = '0;
                        frame_bad  = er_seen_reg | gmii_rx_er | (mii_select & phase_reg);
                        if (count_reg == 3'(LINE_LEN)) begin
                            fcs_bad        = (crc_reg != CRC_RESIDUE);
                            tdata_next     = line_reg[LINE_LEN-1];
                            tvalid_next    = 1'b1;
                            tlast_next     = 1'b1;
                            tuser_next     = frame_bad | fcs_bad;
                            bad_frame_next = frame_bad;
                            bad_fcs_next   = fcs_bad;
                        end else if (count_reg != 3'd0) begin
                            // Too short to hold a full FCS: flush the oldest byte as bad.
                            tdata_next     = line_reg[count_reg - 3'd1];
                            tvalid_next    = 1'b1;
                            tlast_next     = 1'b1;
                            tuser_next     = 1'b1;
                            bad_frame_next = 1'b1;
                        end else if (mii_select && phase_reg) begin
                            bad_frame_next = 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (!gmii_rx_dv) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            crc_reg       <= '1;
            er_seen_reg   <= 1'b0;
            phase_reg     <= 1'b0;
            lo_nib_reg    <= '0;
            prev_nib_reg  <= '0;
            tdata_reg     <= '0;
            tvalid_reg    <= 1'b0;
            tlast_reg     <= 1'b0;
            tuser_reg     <= 1'b0;
            start_reg     <= 1'b0;
            bad_frame_reg <= 1'b0;
            bad_fcs_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            crc_reg       <= crc_next;
            er_seen_reg   <= er_seen_next;
            phase_reg     <= phase_next;
            lo_nib_reg    <= lo_nib_next;
            prev_nib_reg  <= prev_nib_next;
            tdata_reg     <= tdata_next;
            tvalid_reg    <= tvalid_next;
            tlast_reg     <= tlast_next;
            tuser_reg     <= tuser_next;
            start_reg     <= start_next;
            bad_frame_reg <= bad_frame_next;
            bad_fcs_reg   <= bad_fcs_next;
        end
    end

    // Delay line: index 0 newest, LINE_LEN-1 oldest once full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINE_LEN; i++) begin
                line_reg[i] <= '0;
            end
        end else if (shift_en) begin
            line_reg[0] <= cur_byte;
            for (int i = 1; i < LINE_LEN; i++) begin
                line_reg[i] <= line_reg[i-1];
            end
        end
    end

    // Registered results are shown only on enabled cycles, so each beat and
    // pulse is visible exactly once even when clk_enable toggles.
    assign m_axis_rx.tdata  = tdata_reg;
    assign m_axis_rx.tvalid = tvalid_reg & clk_enable;
    assign m_axis_rx.tlast  = tlast_reg & clk_enable;
    assign m_axis_rx.tuser  = USER_W'(tuser_reg & clk_enable);
    assign start_packet     = start_reg & clk_enable;
    assign error_bad_frame  = bad_frame_reg & clk_enable;
    assign error_bad_fcs    = bad_fcs_reg & clk_enable;
endmodule
